// File: rtl/io_bus_packet_loader.sv
// Packs pairs of 32-bit CPU bus words into 64-bit RAM writes at sequential addresses.
// Each packet is a length header followed by data; the header is checked against RAM capacity.
module io_bus_packet_loader #(
    parameter int RAM_ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH        = 64,
    parameter int RAM_DEPTH         = 6000,
    parameter int BUS_WIDTH         = 32
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         INT,
    input  logic                         Load_Process,
    input  logic                         Start,
    input  logic [RAM_ADDRESS_WIDTH-1:0] Base_Address,
    input  logic [BUS_WIDTH-1:0]         Bus_Data,
    output logic                         WR_Enable,
    output logic [RAM_ADDRESS_WIDTH-1:0] WR_Address,
    output logic [DATA_WIDTH-1:0]        WR_Data,
    output logic                         Busy,
    output logic                         Done_Loading,
    output logic                         Error,
    output logic [RAM_ADDRESS_WIDTH-1:0] Words_Written
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_LOW    = 3'd2,
        S_HIGH   = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    localparam logic [RAM_ADDRESS_WIDTH:0] DEPTH_C = (RAM_ADDRESS_WIDTH + 1)'(RAM_DEPTH);
    localparam logic [RAM_ADDRESS_WIDTH-1:0] ZERO_A = {RAM_ADDRESS_WIDTH{1'b0}};

    state_t                         state_q, state_d;
    logic [RAM_ADDRESS_WIDTH-1:0]   base_q, base_d;
    logic [RAM_ADDRESS_WIDTH-1:0]   n_q, n_d;
    logic [BUS_WIDTH-1:0]           low_q, low_d;
    logic [RAM_ADDRESS_WIDTH-1:0]   words_q, words_d;
    logic                           wr_en_q, wr_en_d;
    logic [RAM_ADDRESS_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]          wr_data_q, wr_data_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           error_q, error_d;

    logic [RAM_ADDRESS_WIDTH-1:0]   hdr_n_s;
    logic [RAM_ADDRESS_WIDTH:0]     hdr_end_s;
    logic [RAM_ADDRESS_WIDTH-1:0]   words_inc_s;

    assign hdr_n_s     = Bus_Data[RAM_ADDRESS_WIDTH-1:0];
    // One extra bit so Base+N cannot wrap past the capacity check.
    assign hdr_end_s   = {1'b0, base_q} + {1'b0, hdr_n_s};
    assign words_inc_s = words_q + {{(RAM_ADDRESS_WIDTH-1){1'b0}}, 1'b1};

    // Next-state and output decode; withdrawing Load_Process beats any INT in the same cycle.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        n_d       = n_q;
        low_d     = low_q;
        words_d   = words_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        error_d   = error_q;
        case (state_q)
            S_IDLE: begin
                if (Start && Load_Process) begin
                    state_d = S_HEADER;
                    base_d  = Base_Address;
                    words_d = ZERO_A;
                    error_d = 1'b0;
                    low_d   = {BUS_WIDTH{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HEADER: begin
                if (!Load_Process) begin
                    state_d = S_IDLE;
                end else if (INT) begin
                    n_d = hdr_n_s;
                    if (hdr_n_s == ZERO_A) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (hdr_end_s > DEPTH_C) begin
                        error_d = 1'b1;
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_LOW;
                    end
                end else begin
                    state_d = S_HEADER;
                end
            end
            S_LOW: begin
                if (!Load_Process) begin
                    state_d = S_IDLE;
                    low_d   = {BUS_WIDTH{1'b0}};
                end else if (INT) begin
                    low_d   = Bus_Data;
                    state_d = S_HIGH;
                end else begin
                    state_d = S_LOW;
                end
            end
            S_HIGH: begin
                if (!Load_Process) begin
                    state_d = S_IDLE;
                    low_d   = {BUS_WIDTH{1'b0}};
                end else if (INT) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = base_q + words_q;
                    wr_data_d = {Bus_Data, low_q};
                    words_d   = words_inc_s;
                    if (words_inc_s == n_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_LOW;
                    end
                end else begin
                    state_d = S_HIGH;
                end
            end
            S_ERROR: begin
                if (!Load_Process) begin
                    state_d = S_IDLE;
                end else if (Start) begin
                    state_d = S_HEADER;
                    base_d  = Base_Address;
                    words_d = ZERO_A;
                    error_d = 1'b0;
                    low_d   = {BUS_WIDTH{1'b0}};
                end else begin
                    state_d = S_ERROR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_HEADER) || (state_d == S_LOW) || (state_d == S_HIGH);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            base_q    <= ZERO_A;
            n_q       <= ZERO_A;
            low_q     <= {BUS_WIDTH{1'b0}};
            words_q   <= ZERO_A;
            wr_en_q   <= 1'b0;
            wr_addr_q <= ZERO_A;
            wr_data_q <= {DATA_WIDTH{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            n_q       <= n_d;
            low_q     <= low_d;
            words_q   <= words_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign WR_Enable     = wr_en_q;
    assign WR_Address    = wr_addr_q;
    assign WR_Data       = wr_data_q;
    assign Busy          = busy_q;
    assign Done_Loading  = done_q;
    assign Error         = error_q;
    assign Words_Written = words_q;

endmodule

// File: tb/tb_io_bus_packet_loader.sv
// Scoreboard bench for io_bus_packet_loader: stimulus queues expected write/done events,
// a negedge monitor pops and compares whenever the DUT shows WR_Enable or Done_Loading.
module tb_io_bus_packet_loader;

    logic        CLK;
    logic        RST;
    logic        INT;
    logic        Load_Process;
    logic        Start;
    logic [12:0] Base_Address;
    logic [31:0] Bus_Data;
    logic        WR_Enable;
    logic [12:0] WR_Address;
    logic [63:0] WR_Data;
    logic        Busy;
    logic        Done_Loading;
    logic        Error;
    logic [12:0] Words_Written;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        w;
        logic [12:0] a;
        logic [63:0] d;
        logic        done;
    } ev_t;

    ev_t exp_q[$];

    io_bus_packet_loader dut (
        .CLK(CLK), .RST(RST), .INT(INT), .Load_Process(Load_Process), .Start(Start),
        .Base_Address(Base_Address), .Bus_Data(Bus_Data), .WR_Enable(WR_Enable),
        .WR_Address(WR_Address), .WR_Data(WR_Data), .Busy(Busy),
        .Done_Loading(Done_Loading), .Error(Error), .Words_Written(Words_Written)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Monitor: every presented write or done pulse must match the head of the queue.
    always @(negedge CLK) begin
        ev_t e;
        if (WR_Enable || Done_Loading) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event actual we=%0b addr=%0d data=%h done=%0b required none",
                         WR_Enable, WR_Address, WR_Data, Done_Loading);
            end else begin
                e = exp_q.pop_front();
                if (WR_Enable !== e.w || Done_Loading !== e.done ||
                    (e.w && (WR_Address !== e.a || WR_Data !== e.d))) begin
                    errors++;
                    $display("FAIL event actual we=%0b addr=%0d data=%h done=%0b required we=%0b addr=%0d data=%h done=%0b",
                             WR_Enable, WR_Address, WR_Data, Done_Loading, e.w, e.a, e.d, e.done);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_w(input logic [12:0] a, input logic [63:0] d, input logic done);
        ev_t e;
        e.w = 1'b1; e.a = a; e.d = d; e.done = done;
        exp_q.push_back(e);
    endtask

    task automatic push_done();
        ev_t e;
        e.w = 1'b0; e.a = 13'd0; e.d = 64'd0; e.done = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic start(input logic [12:0] base);
        Start = 1'b1;
        Base_Address = base;
        tick();
        Start = 1'b0;
    endtask

    task automatic send(input logic [31:0] w, input int gap);
        INT = 1'b1;
        Bus_Data = w;
        tick();
        INT = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s actual=%0d_pending required=0_pending", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_we"}, 64'(WR_Enable), 64'd0);
        chk({name, "_addr"}, 64'(WR_Address), 64'd0);
        chk({name, "_data"}, WR_Data, 64'd0);
        chk({name, "_busy"}, 64'(Busy), 64'd0);
        chk({name, "_done"}, 64'(Done_Loading), 64'd0);
        chk({name, "_err"}, 64'(Error), 64'd0);
        chk({name, "_words"}, 64'(Words_Written), 64'd0);
    endtask

    task automatic basic_run(input int gap, input string name);
        push_w(13'd100, 64'h22222222_11111111, 1'b0);
        push_w(13'd101, 64'h44444444_33333333, 1'b1);
        start(13'd100);
        chk({name, "_busy_rise"}, 64'(Busy), 64'd1);
        send(32'd2, gap);
        send(32'h11111111, gap);
        send(32'h22222222, gap);
        send(32'h33333333, gap);
        send(32'h44444444, gap);
        chk({name, "_words"}, 64'(Words_Written), 64'd2);
        chk({name, "_busy_fall"}, 64'(Busy), 64'd0);
        drain(name);
    endtask

    initial begin
        RST = 1'b0; INT = 1'b0; Load_Process = 1'b0; Start = 1'b0;
        Base_Address = 13'd0; Bus_Data = 32'd0;
        repeat (3) tick();
        chk_all_zero("reset");
        RST = 1'b1;
        Load_Process = 1'b1;
        tick();

        basic_run(0, "basic");
        basic_run(3, "gaps");

        // Capacity overflow, then restart straight from ERROR.
        start(13'd5990);
        send(32'd20, 0);
        chk("ovf_err", 64'(Error), 64'd1);
        chk("ovf_busy", 64'(Busy), 64'd0);
        tick();
        chk("ovf_sticky", 64'(Error), 64'd1);
        push_w(13'd0, 64'hBBBB0002_AAAA0001, 1'b1);
        start(13'd0);
        chk("restart_err_clr", 64'(Error), 64'd0);
        chk("restart_busy", 64'(Busy), 64'd1);
        send(32'd1, 0);
        send(32'hAAAA0001, 0);
        send(32'hBBBB0002, 0);
        drain("restart");

        // Base+N one past capacity, abort to IDLE, then exactly-at-capacity packet.
        start(13'd5999);
        send(32'hFFFF0002, 0);
        chk("edge_ovf_err", 64'(Error), 64'd1);
        Load_Process = 1'b0;
        tick();
        Load_Process = 1'b1;
        chk("err_thru_idle", 64'(Error), 64'd1);
        push_w(13'd5999, 64'h0000CAFE_0000BEEF, 1'b1);
        start(13'd5999);
        chk("edge_err_clr", 64'(Error), 64'd0);
        send(32'd1, 0);
        send(32'h0000BEEF, 0);
        send(32'h0000CAFE, 0);
        drain("edge_fit");

        // Zero-length header.
        push_done();
        start(13'd50);
        send(32'd0, 0);
        chk("zero_busy", 64'(Busy), 64'd0);
        chk("zero_words", 64'(Words_Written), 64'd0);
        drain("zero");

        // Abort: withdraw load mode on the same edge as a high-half INT.
        push_w(13'd200, 64'h000000B0_000000A0, 1'b0);
        start(13'd200);
        send(32'd3, 0);
        send(32'h000000A0, 0);
        send(32'h000000B0, 0);
        send(32'h000000C0, 0);
        INT = 1'b1; Bus_Data = 32'h000000D0; Load_Process = 1'b0;
        tick();
        INT = 1'b0;
        chk("abort_busy", 64'(Busy), 64'd0);
        chk("abort_words", 64'(Words_Written), 64'd1);
        send(32'h000000E0, 1);
        Load_Process = 1'b1;
        send(32'h000000F0, 2);
        chk("abort_words_hold", 64'(Words_Written), 64'd1);
        drain("abort");

        // Reset on the edge of a high-half INT.
        start(13'd300);
        send(32'd2, 0);
        send(32'h12345678, 0);
        RST = 1'b0; INT = 1'b1; Bus_Data = 32'h9ABCDEF0;
        tick();
        INT = 1'b0;
        chk_all_zero("midrst");
        RST = 1'b1;
        send(32'h55555555, 3);
        drain("midrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_bus_packet_loader.md
# io_bus_packet_loader

Upstream loading stage for the solver RAM. It takes 32-bit words strobed by the CPU on the bus, pairs them into 64-bit RAM words, and drives the RAM write port at sequential addresses. Each packet is a header word followed by data words. The block checks the header against RAM capacity, pulses a completion flag when the last word is written, and aborts cleanly when the load mode is withdrawn.

## Interface
- RAM_ADDRESS_WIDTH, 13, RAM address width
- DATA_WIDTH, 64, RAM word width; always 2 × BUS_WIDTH
- RAM_DEPTH, 6000, number of valid RAM words (addresses 0..RAM_DEPTH-1)
- BUS_WIDTH, 32, CPU bus word width
- CLK  in  1  sole clock; all state updates on the rising edge
- RST  in  1  reset, synchronous, active-low; sampled on the CLK rising edge
- INT  in  1  CPU strobe; Bus_Data is valid in this cycle; one word per cycle with INT high
- Load_Process  in  1  1 = load mode; 0 forces abort to IDLE
- Start  in  1  single-cycle pulse that begins a packet
- Base_Address  in  RAM_ADDRESS_WIDTH  first RAM address of the packet; sampled on the Start edge
- Bus_Data  in  BUS_WIDTH  CPU bus word
- WR_Enable  out  1  RAM write strobe
- WR_Address  out  RAM_ADDRESS_WIDTH  RAM write address
- WR_Data  out  DATA_WIDTH  RAM write data, {high half, low half}
- Busy  out  1  high in HEADER, LOW and HIGH states
- Done_Loading  out  1  one-cycle completion pulse
- Error  out  1  sticky capacity-overflow flag; cleared by Start or reset
- Words_Written  out  RAM_ADDRESS_WIDTH  count of 64-bit writes in the current packet

## Operation
- **States:** IDLE, HEADER, LOW, HIGH, ERROR.
- **IDLE:**
  - Start=1 with Load_Process=1 latches Base_Address, clears Words_Written and Error, and moves to HEADER.
  - INT in IDLE is ignored, including in the Start cycle.
- **HEADER:** on INT, N = Bus_Data[RAM_ADDRESS_WIDTH-1:0]. Bus_Data upper bits are ignored.
  - N=0 → Done_Loading pulse, then IDLE.
  - Base+N > RAM_DEPTH → Error=1, go to ERROR, no writes. Compute the sum at RAM_ADDRESS_WIDTH+1 bits so it cannot wrap.
  - Otherwise → LOW.
- **LOW:** on INT, latch Bus_Data as the low half and go to HIGH.
- **HIGH:** on INT, issue the write:
  - WR_Data = {Bus_Data, low half}
  - WR_Address = Base + Words_Written
  - Words_Written increments
  - If Words_Written reaches N → Done_Loading and go to IDLE; else → LOW.
- **ERROR:** holds until Start (restarts at HEADER) or Load_Process=0 (→ IDLE). Error stays high through the IDLE transition until the next Start.
- **Start while Busy:** ignored.
- **Load_Process=0 in any Busy state:**
  - Next state is IDLE, with no Done_Loading.
  - Writes already issued stand. A pending low half is discarded.
  - Words_Written holds its value for inspection.
  - Abort takes priority over an INT in the same cycle, so no write is issued for that INT.
- **Address arithmetic:** unsigned, RAM_ADDRESS_WIDTH bits. It never exceeds RAM_DEPTH-1 because of the header check.

## Timing
- **Reset:** RST=0 at an edge puts the FSM in IDLE and clears every output (WR_Enable, WR_Address, WR_Data, Busy, Done_Loading, Error, Words_Written all 0) and all internal latches. This applies mid-packet as well; a write that would have been issued on that edge is suppressed.
- **Registered outputs:** all outputs are registered. An event sampled at edge k is visible during cycle k+1.
- **Write timing:** for the INT carrying a high half, sampled at edge k:
  - WR_Enable=1 for exactly cycle k+1, with WR_Address and WR_Data valid alongside it.
  - WR_Enable=0 otherwise.
- **Done_Loading:** high for exactly one cycle, the same cycle as the final WR_Enable. For N=0 it is the cycle after the header edge.
- **Busy timing:** Busy rises the cycle after the Start edge. It falls in the cycle Done_Loading is high, and the cycle after an abort.
- **Throughput:** back-to-back INT is supported. A 2N-word burst with no gaps yields N writes, one every 2 cycles, with no stalls. Gaps of any length between INT strobes are allowed.
- **Latency:** header edge to first write is 2 edges minimum (header, low), with the write visible after the high edge.

## Test plan
- **Basic packet:** reset; Start with Base=100; INT words 2, 0x11111111, 0x22222222, 0x33333333, 0x44444444 back-to-back.
  - Expect writes (100, 0x2222222211111111) and (101, 0x4444444433333333).
  - Done_Loading in the second write cycle; Words_Written=2.
- **Capacity overflow:** Base=5990, header N=20.
  - Expect Error=1, no WR_Enable, FSM in ERROR.
  - A new Start with Base=0, N=1 clears Error and writes address 0.
- **Zero-length header:** header N=0.
  - Expect a Done_Loading pulse one cycle after the header edge, no writes, Busy low afterwards.
- **Abort after one write:** Load_Process dropped after the first write and one low half of a 3-word packet.
  - Expect IDLE, exactly 1 write, no Done_Loading, Words_Written=1.
  - A subsequent INT is ignored.
- **Reset mid-operation and stall gaps:**
  - RST=0 on the edge of a high-half INT → no write, all outputs 0 next cycle.
  - Separately, 3-cycle gaps between INTs → identical data and addresses to the gap-free run.
